exu_result_queue: RTL
=====================

// Module: exu_result_queue
// PURPOSE
//  Execute-to-writeback result buffer. Captures each result from the ALU
//  functional units (DIFF, add, shift, logic), with its destination register
//  index and result flags. Drains results in order to the register-file
//  write port over a valid/ready handshake.
//  Also flags source-register hazards so the operand-fetch stage can stall.
// PARAMETERS
//  DATA_W  32  result width
//  REG_AW  5   register index width (32 GPRs, reg 0 hardwired zero)
//  DEPTH   4   queue entries; power of two, >=2
// PORTS
//  clk         in   1       clock, all state on rising edge
//  rst         in   1       asynchronous, active-low reset
//  flush       in   1       sync clear of all entries (branch redirect)
//  in_valid    in   1       producer has a result
//  in_ready    out  1       queue can accept (= !full)
//  in_result   in   DATA_W  ALU result (e.g. DIFF out)
//  in_rd       in   REG_AW  destination register
//  in_wen      in   1       result must be written back
//  out_valid   out  1       head entry present
//  out_ready   in   1       register file accepts head
//  out_result  out  DATA_W  head result
//  out_rd      out  REG_AW  head destination
//  out_wen     out  1       head write enable (0 if rd==0)
//  out_zero    out  1       head result == 0
//  out_sign    out  1       head result[DATA_W-1]
//  rs_idx      in   REG_AW  fetch-stage source A
//  rt_idx      in   REG_AW  fetch-stage source B
//  hazard      out  1       rs/rt matches a pending write
//  count       out  log2(DEPTH)+1  occupancy
// BEHAVIOUR
//  - Reset (rst=0, async): all entries invalid, pointers 0, count 0,
//    out_valid 0, in_ready 1, hazard 0, out_* data 0.
//  - Push when in_valid&&in_ready. Pop when out_valid&&out_ready.
//    Both may fire in one cycle; count is then unchanged.
//  - in_ready = (count!=DEPTH), combinational from registered count.
//    When full, a same-cycle pop does NOT enable a push.
//  - Latency: a push at edge N gives out_valid=1 after edge N (1 cycle).
//    No combinational in->out path.
//  - Flags are computed at push and stored with the entry:
//    zero=(in_result==0); sign=in_result[DATA_W-1].
//  - wen is stored as in_wen && (in_rd!=0). A write to reg 0 still passes
//    through in order, but with out_wen=0.
//  - Pointers are REG index width log2(DEPTH) and wrap modulo DEPTH.
//    Full/empty come from count, not pointer compare.
//  - Outputs stay stable while out_valid && !out_ready (AXI-style hold).
//  - hazard=1 iff some valid entry has wen=1 and rd==rs_idx or rd==rt_idx.
//    The head is included even when it pops this cycle (conservative).
//    Index 0 never matches. hazard is combinational from state.
//  - flush has priority over push and pop: next state is empty and
//    in_ready=1. A push in the flush cycle is dropped.
//  - Reset mid-operation discards all entries immediately; no partial
//    write is emitted.
// STRUCTURE
//  - Shared package (kgp_pkg): DATA_W, REG_AW, REG_ZERO constant, and the
//    result-entry struct/field layout {result, rd, wen, zero, sign}.
//  - One sub-module is natural: exu_hazard_cmp. This is the per-entry
//    rd vs. rs/rt comparator, replicated DEPTH times and OR-reduced.
//  - Storage is a flop array (no RAM inference). Head/tail pointers and
//    count are registers.
// TESTING
//  1. Reset, then push {result=2, rd=3, wen=1} -> next cycle out_valid=1,
//     out_result=2, out_rd=3, out_wen=1, out_zero=0, out_sign=0, count=1.
//  2. Push 4 entries with out_ready=0 -> count=4, in_ready=0. A 5th push
//     is ignored. Then draining with out_ready=1 yields the results in
//     push order.
//  3. At count=2, push and pop in the same cycle -> count stays 2, head
//     advances. Repeat 10x so the pointers wrap; order is preserved.
//  4. Push {result=0, rd=0, wen=1} -> out_wen=0, out_zero=1. Push
//     32'h8000_0000 -> out_sign=1.
//  5. Entry rd=7, wen=1 pending with rs_idx=7 -> hazard=1. With rt_idx=7
//     -> hazard=1. rd=0 entry and rs_idx=0 -> hazard=0. After pop -> 0.
//  6. Assert flush with 3 entries plus a concurrent push -> next cycle
//     count=0, out_valid=0. Assert rst low mid-drain -> outputs go to 0
//     at once, without waiting for clk.

Source files
------------

// File: rtl/kgp_pkg.sv
// Shared widths and the result-queue entry layout for the execute/writeback path.
package kgp_pkg;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [REG_AW-1:0] rd;
        logic              wen;
        logic              zero;
        logic              sign;
    } rq_entry_t;

    // Flags are captured once at push so the drain side never re-examines data.
    function automatic rq_entry_t mk_entry(input logic [DATA_W-1:0] res,
                                           input logic [REG_AW-1:0] rd,
                                           input logic              wen);
        rq_entry_t e;
        e.result = res;
        e.rd     = rd;
        e.wen    = wen && (rd != REG_ZERO);
        e.zero   = (res == '0);
        e.sign   = res[DATA_W-1];
        return e;
    endfunction
endpackage

// File: rtl/exu_hazard_cmp.sv
// One queue entry's destination compared against both fetch-stage sources.
module exu_hazard_cmp
    import kgp_pkg::*;
(
    input  logic              valid_i,
    input  logic              wen_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic [REG_AW-1:0] rs_i,
    input  logic [REG_AW-1:0] rt_i,
    output logic              hit_o
);
    assign hit_o = valid_i && wen_i && (rd_i != REG_ZERO) &&
                   ((rd_i == rs_i) || (rd_i == rt_i));
endmodule

// File: rtl/exu_result_queue.sv
// In-order ALU result buffer feeding the register-file write port, with
// source-register hazard detection against all pending writes.
module exu_result_queue
    import kgp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_result,
    input  logic [REG_AW-1:0]          in_rd,
    input  logic                       in_wen,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_result,
    output logic [REG_AW-1:0]          out_rd,
    output logic                       out_wen,
    output logic                       out_zero,
    output logic                       out_sign,
    input  logic [REG_AW-1:0]          rs_idx,
    input  logic [REG_AW-1:0]          rt_idx,
    output logic                       hazard,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    rq_entry_t       entry_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push, pop;
    rq_entry_t       head_e;

    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    // Flush wins: a push presented alongside it is dropped.
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready;
    assign count     = count_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + PW'(1);
            if (pop)  head_d = head_q + PW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
            for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (flush) begin
                vld_q <= '0;
            end else begin
                // Push and pop never target the same slot: push needs room, pop needs data.
                if (pop) vld_q[head_q] <= 1'b0;
                if (push) begin
                    vld_q[tail_q]   <= 1'b1;
                    entry_q[tail_q] <= mk_entry(in_result, in_rd, in_wen);
                end
            end
        end
    end

    assign head_e     = entry_q[head_q];
    assign out_result = out_valid ? head_e.result : '0;
    assign out_rd     = out_valid ? head_e.rd     : '0;
    assign out_wen    = out_valid && head_e.wen;
    assign out_zero   = out_valid && head_e.zero;
    assign out_sign   = out_valid && head_e.sign;

    logic [DEPTH-1:0] hit;
    for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
        exu_hazard_cmp u_cmp (
            .valid_i (vld_q[g]),
            .wen_i   (entry_q[g].wen),
            .rd_i    (entry_q[g].rd),
            .rs_i    (rs_idx),
            .rt_i    (rt_idx),
            .hit_o   (hit[g])
        );
    end
    assign hazard = |hit;
endmodule
